matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 500: clock cycles each row is driven.
REQ-002 Parameter BLANK, default 4: clock cycles of all-off blanking before each row.
REQ-003 Parameter BLINK_FRAMES, default 16: frames per cursor blink half-period.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  power switch (ch7); 1 = scanning enabled.
REQ-007 mode  input  1  display select (ch6); 0 = placement buffer, 1 = attack buffer.
REQ-008 wr_en  input  1  write strobe, one row per asserted cycle.
REQ-009 wr_buf  input  1  target buffer: 0 = placement, 1 = attack.
REQ-010 wr_row  input  3  target row, 0..6 valid.
REQ-011 wr_data  input  5  column bits for target row, bit0 = column 0.
REQ-012 cur_row  input  3  cursor row, 0..6.
REQ-013 cur_col  input  3  cursor column, 0..4.
REQ-014 row_sel  output  7  one-hot row drive, bit n = row Ln, active-high.
REQ-015 col_out  output  5  column drive for the active row, active-high.
REQ-016 frame_start  output  1  one-cycle pulse on the first DRIVE cycle of row 0.
REQ-017 wr_err  output  1  one-cycle pulse, cycle after a write with wr_row = 7.

Function
REQ-018 Storage: two 7x5-bit buffers (placement, attack); write lands at the clock edge where wr_en = 1 and wr_row <= 6.
REQ-019 wr_row = 7 shall leave both buffers unchanged and pulse wr_err the next cycle.
REQ-020 FSM states: IDLE, BLANK, DRIVE; row counter r in 0..6; cycle counter sized for max(DWELL, BLANK).
REQ-021 IDLE: row_sel = 0, col_out = 0; if en = 1, go to BLANK with r = 0 and cycle count 0.
REQ-022 BLANK: row_sel = 0, col_out = 0 for exactly BLANK cycles, then DRIVE.
REQ-023 On the BLANK->DRIVE edge, snapshot row r of the active buffer into a column register; col_out is driven from this register for the whole DRIVE period.
REQ-024 DRIVE: row_sel = (1 << r), col_out = snapshot, for exactly DWELL cycles, then BLANK with r incremented; r wraps 6 -> 0.
REQ-025 Active buffer is sampled from mode only when a DRIVE of row 0 begins; a mode change mid-frame takes effect next frame.
REQ-026 A write to the row currently in DRIVE shall not alter col_out until that row's next DRIVE.
REQ-027 Simultaneous write and snapshot of the same row/buffer: the snapshot takes the pre-write value.
REQ-028 Frame counter increments at each frame_start; blink phase toggles when it reaches BLINK_FRAMES, then the counter clears.
REQ-029 With active buffer = attack, r = cur_row and blink phase = 1, col_out bit cur_col shall be inverted; cur_col > 4 or cur_row > 6 means no inversion.
REQ-030 en = 0 in any state: on the next cycle row_sel = 0, col_out = 0, state IDLE, r = 0; buffer contents are retained.
REQ-031 row_sel shall never have more than one bit set; an all-zero cycle (BLANK >= 1) shall separate any two distinct rows.
REQ-032 Writes are accepted in every state, including IDLE.

Reset
REQ-033 reset = 1 at a clock edge: state IDLE, r = 0, counters 0, blink phase 0, both buffers all-zero, snapshot 0.
REQ-034 Reset outputs: row_sel = 0, col_out = 0, frame_start = 0, wr_err = 0.
REQ-035 Reset shall override en and wr_en in the same cycle; reset mid-DRIVE blanks outputs the next cycle.

Verification (DWELL = 3, BLANK = 1, BLINK_FRAMES = 2)
REQ-036 Write placement rows 0..6 = 5'h01,02,04,08,10,1F,15; en = 1, mode = 0 -> row_sel 7'h01 with col 5'h01 for 3 cycles, 1 blank cycle, 7'h02/5'h02, ..., 7'h40/5'h15, then wrap to row 0; period 28 cycles.
REQ-037 frame_start pulses exactly once every 28 cycles, coincident with row_sel = 7'h01.
REQ-038 Toggle mode 0->1 while row 3 is driven -> rows 4..6 still show placement data; attack data from the next row 0 onward.
REQ-039 Attack row 2 = 5'h00, cur_row = 2, cur_col = 4, mode = 1 -> row 2 col_out = 5'h10 in frames 3-4, 5'h00 in frames 1-2, pattern repeating.
REQ-040 wr_en with wr_row = 7, wr_data = 5'h1F -> wr_err high one cycle, display unchanged; en dropped mid-DRIVE -> outputs 0 next cycle, re-enable restarts at row 0 after 1 blank cycle.
REQ-041 reset asserted mid-frame -> outputs 0 next cycle; after release with en = 1, all rows show col_out = 5'h00.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: scans a 7-row x 5-column LED matrix from one of two
// frame buffers (placement / attack). Each row gets a blanking gap and then
// a dwell period. The attack view also blinks a cursor cell.
module matrix_scan_ctrl #(
  parameter int DWELL        = 500,
  parameter int BLANK        = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode,
  input  logic       wr_en,
  input  logic       wr_buf,
  input  logic [2:0] wr_row,
  input  logic [4:0] wr_data,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  output logic [6:0] row_sel,
  output logic [4:0] col_out,
  output logic       frame_start,
  output logic       wr_err
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      col_q, col_d;
  logic            act_q, act_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            blink_q, blink_d;
  logic            wr_err_q, wr_err_d;
  // Row 7 is never written; it exists so a 3-bit row index is always in range.
  logic [4:0]      mem_q [2][8];
  logic [4:0]      mem_d [2][8];

  logic            rd_buf;
  logic [4:0]      rd_data;
  logic            drive;
  logic            cur_hit;

  // Row 0 snapshots from the freshly sampled mode; later rows use the latched buffer.
  assign rd_buf  = (r_q == 3'd0) ? mode : act_q;
  assign rd_data = mem_q[rd_buf][r_q];

  // Buffer write path; row 7 is rejected and flagged on the next cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[b][i] = mem_q[b][i];
      end
    end
    wr_err_d = wr_en && (wr_row == 3'd7);
    if (wr_en && (wr_row != 3'd7)) begin
      mem_d[wr_buf][wr_row] = wr_data;
    end
  end

  // Scan sequencing: blank gap, snapshot, dwell, next row; en low forces idle.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    act_d   = act_q;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (!en) begin
      state_d = S_IDLE;
      r_d     = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          r_d     = 3'd0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == CW'(BLANK - 1)) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
            col_d   = rd_data;
            if (r_q == 3'd0) begin
              // New frame: latch display buffer and advance blink timing so
              // the whole frame shows one consistent blink phase.
              act_d = mode;
              if (fcnt_q == FW'(BLINK_FRAMES)) begin
                blink_d = ~blink_q;
                fcnt_d  = FW'(1);
              end else begin
                fcnt_d = fcnt_q + FW'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DRIVE: begin
          if (cnt_q == CW'(DWELL - 1)) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            r_d     = (r_q == 3'd6) ? 3'd0 : r_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          r_d     = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      r_q      <= 3'd0;
      cnt_q    <= '0;
      col_q    <= 5'd0;
      act_q    <= 1'b0;
      fcnt_q   <= '0;
      blink_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      act_q    <= act_d;
      fcnt_q   <= fcnt_d;
      blink_q  <= blink_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Frame buffers, cleared by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[b][i] <= reset ? 5'd0 : mem_d[b][i];
      end
    end
  end

  assign drive       = (state_q == S_DRIVE);
  assign cur_hit     = act_q && blink_q && (cur_row == r_q);
  assign frame_start = drive && (r_q == 3'd0) && (cnt_q == '0);
  assign wr_err      = wr_err_q;

  // One-hot row decode, only while driving.
  for (genvar gi = 0; gi < 7; gi++) begin : g_row
    assign row_sel[gi] = drive && (r_q == 3'(gi));
  end

  // Column drive with the cursor cell inverted during the lit blink phase.
  for (genvar gi = 0; gi < 5; gi++) begin : g_col
    assign col_out[gi] = drive && (col_q[gi] ^ (cur_hit && (cur_col == 3'(gi))));
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed + randomized stimulus against a time-indexed
// reference model of the scan sequence.
module tb_matrix_scan_ctrl;
  localparam int D    = 3;
  localparam int B    = 1;
  localparam int BF   = 2;
  localparam int SLOT = B + D;
  localparam int PER  = 7 * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_buf = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [2:0] cur_row = 3'd2;
  logic [2:0] cur_col = 3'd4;
  logic [6:0] row_sel;
  logic [4:0] col_out;
  logic       frame_start;
  logic       wr_err;

  matrix_scan_ctrl #(.DWELL(D), .BLANK(B), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .wr_en(wr_en), .wr_buf(wr_buf), .wr_row(wr_row), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col),
    .row_sel(row_sel), .col_out(col_out),
    .frame_start(frame_start), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Reference model: m_t counts cycles since scanning (re)started.
  bit         m_run = 0;
  int         m_t = 0;
  logic [4:0] m_buf [2][7];
  logic [4:0] m_snap = 5'd0;
  bit         m_act = 0;
  int         m_frames = 0;
  bit         m_werr = 0;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int p, row, k, phase;
    int exp_rs, exp_col, exp_fs;
    exp_rs = 0; exp_col = 0; exp_fs = 0;
    if (m_run) begin
      p = m_t % PER;
      row = p / SLOT;
      k = p % SLOT;
      if (k >= B) begin
        phase = (m_frames > 0) ? ((m_frames - 1) / BF) % 2 : 0;
        exp_rs = 1 << row;
        exp_col = m_snap;
        if (m_act && phase == 1 && int'(cur_row) == row && cur_col <= 3'd4)
          exp_col = exp_col ^ (1 << cur_col);
        exp_fs = (row == 0 && k == B) ? 1 : 0;
      end
    end
    check_val("row_sel", row_sel, exp_rs);
    check_val("col_out", col_out, exp_col);
    check_val("frame_start", frame_start, exp_fs);
    check_val("wr_err", wr_err, m_werr);
  endtask

  task automatic model_edge();
    int p, row;
    if (reset) begin
      m_run = 0; m_t = 0; m_snap = 0; m_frames = 0; m_werr = 0; m_act = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 7; i++) m_buf[b][i] = 5'd0;
    end else begin
      m_werr = wr_en && (wr_row == 3'd7);
      if (!en) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
      end
      if (m_run) begin
        p = m_t % PER;
        if (p % SLOT == B) begin
          row = p / SLOT;
          if (row == 0) begin
            m_act = mode;
            m_frames++;
          end
          m_snap = m_buf[m_act][row];
        end
      end
      if (wr_en && wr_row <= 3'd6) m_buf[wr_buf][wr_row] = wr_data;
    end
  endtask

  // One clock: check at negedge+1, model the posedge, return at next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input bit b, input int row, input int data);
    wr_en = 1'b1; wr_buf = b; wr_row = 3'(row); wr_data = 5'(data);
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [4:0] pat [7];
    pat = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h15};
    @(negedge clk);
    run(3);
    reset = 1'b0;
    run(2);
    for (int i = 0; i < 7; i++) write(1'b0, i, pat[i]);
    for (int i = 0; i < 7; i++) write(1'b1, i, (i == 2) ? 0 : $urandom_range(0, 31));
    en = 1'b1; mode = 1'b0;
    run(2 * PER + 13);
    mode = 1'b1;                       // mid-frame switch to attack view
    run(6 * PER);
    write(1'b0, 7, 5'h1F);             // rejected write
    run(PER);
    write(1'b1, 2, 5'h00);
    run(5);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(PER + 6);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(2 * PER);
    for (int i = 0; i < 1500; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_buf = 1'($urandom_range(0, 1));
      wr_row = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) begin
        cur_row = 3'($urandom_range(0, 7));
        cur_col = 3'($urandom_range(0, 7));
      end
      en = ($urandom_range(0, 99) != 0);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    wr_en = 1'b0; reset = 1'b0; en = 1'b1;
    run(PER);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
